// File: rtl/fpga_boot_seq_pkg.sv
// rtl/fpga_boot_seq_pkg.sv - shared types and default parameters for the boot sequencer
package fpga_boot_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_DDR_RST    = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_SOC_RST    = 3'd3,
    ST_RUN        = 3'd4,
    ST_ERROR      = 3'd5
  } boot_state_e;

  localparam int unsigned DefLockDebounceCycles = 1024;
  localparam int unsigned DefRstHoldCycles      = 64;
  localparam int unsigned DefCalibTimeoutCycles = 2 ** 22;
  localparam int unsigned DefMaxRetries         = 3;
  localparam int unsigned DefSyncStages         = 2;
  localparam int unsigned DefCntWidth           = 24;

  function automatic logic holds_ddr_in_reset(boot_state_e st);
    return (st == ST_WAIT_LOCK) || (st == ST_DDR_RST) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/fpga_boot_seq_if.sv
// rtl/fpga_boot_seq_if.sv - board-side signal bundle between clock/DRAM/VIO and the sequencer
interface fpga_boot_seq_if;

  logic       mmcm_locked_i;
  logic       ddr_calib_done_i;
  logic       soft_rst_i;
  logic [1:0] boot_mode_i;
  logic       soc_rst_no;
  logic       ddr_rst_o;
  logic [1:0] boot_mode_o;
  logic [2:0] state_o;
  logic       ready_o;
  logic       calib_timeout_o;

  modport master (
    output mmcm_locked_i, ddr_calib_done_i, soft_rst_i, boot_mode_i,
    input  soc_rst_no, ddr_rst_o, boot_mode_o, state_o, ready_o, calib_timeout_o
  );

  modport slave (
    input  mmcm_locked_i, ddr_calib_done_i, soft_rst_i, boot_mode_i,
    output soc_rst_no, ddr_rst_o, boot_mode_o, state_o, ready_o, calib_timeout_o
  );

endinterface

// File: rtl/fpga_boot_seq_sync.sv
// rtl/fpga_boot_seq_sync.sv - multi-flop synchroniser for asynchronous status bits
module fpga_boot_seq_sync #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Stages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/fpga_boot_seq.sv
// rtl/fpga_boot_seq.sv - power-up sequencer gating DRAM and SoC resets on lock and calibration
module fpga_boot_seq
  import fpga_boot_seq_pkg::*;
#(
  parameter int unsigned LockDebounceCycles = DefLockDebounceCycles,
  parameter int unsigned RstHoldCycles      = DefRstHoldCycles,
  parameter int unsigned CalibTimeoutCycles = DefCalibTimeoutCycles,
  parameter int unsigned MaxRetries         = DefMaxRetries,
  parameter int unsigned SyncStages         = DefSyncStages,
  parameter int unsigned CntWidth           = DefCntWidth
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fpga_boot_seq_if.slave bus
);

  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [CntWidth-1:0] LockLast  = CntWidth'(LockDebounceCycles - 1);
  localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0] CalibLast = CntWidth'(CalibTimeoutCycles - 1);
  localparam logic [RetryW-1:0]   RetryMax  = RetryW'(MaxRetries);

  logic [1:0] raw_status;
  logic [1:0] sync_status;
  logic       lock_s;
  logic       calib_s;

  assign raw_status = {bus.ddr_calib_done_i, bus.mmcm_locked_i};

  fpga_boot_seq_sync #(
    .Stages(SyncStages),
    .Width (2)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (raw_status),
    .q_o  (sync_status)
  );

  assign lock_s  = sync_status[0];
  assign calib_s = sync_status[1];

  boot_state_e       state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [1:0]        boot_mode_q, boot_mode_d;
  logic              timeout_q, timeout_d;
  logic              soc_rst_n_q, ddr_rst_q, ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retry_d     = retry_q;
    boot_mode_d = boot_mode_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (!lock_s)                state_d = ST_WAIT_LOCK;
        else if (cnt_q == LockLast) state_d = ST_DDR_RST;
        if (!lock_s)                cnt_d   = '0;
      end
      ST_DDR_RST: begin
        if (!lock_s)                state_d = ST_WAIT_LOCK;
        else if (cnt_q == HoldLast) state_d = ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        // Calibration completing on the timeout cycle still counts as success.
        if (!lock_s)       state_d = ST_WAIT_LOCK;
        else if (calib_s)  state_d = ST_SOC_RST;
        else if (cnt_q == CalibLast) begin
          timeout_d = 1'b1;
          if (retry_q == RetryMax) begin
            state_d = ST_ERROR;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_DDR_RST;
          end
        end
      end
      ST_SOC_RST: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (bus.soft_rst_i) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s)             state_d = ST_WAIT_LOCK;
        else if (!calib_s)       state_d = ST_DDR_RST;
        else if (bus.soft_rst_i) state_d = ST_SOC_RST;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_WAIT_LOCK;
    endcase

    if (state_d != state_q) cnt_d = '0;
    if ((state_d == ST_SOC_RST) && (state_q != ST_SOC_RST)) boot_mode_d = bus.boot_mode_i;
  end

  // Reset outputs are flopped from the next state so they never glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      retry_q     <= '0;
      boot_mode_q <= '0;
      timeout_q   <= 1'b0;
      soc_rst_n_q <= 1'b0;
      ddr_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      boot_mode_q <= boot_mode_d;
      timeout_q   <= timeout_d;
      soc_rst_n_q <= (state_d == ST_RUN);
      ddr_rst_q   <= holds_ddr_in_reset(state_d);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  assign bus.soc_rst_no      = soc_rst_n_q;
  assign bus.ddr_rst_o       = ddr_rst_q;
  assign bus.boot_mode_o     = boot_mode_q;
  assign bus.state_o         = state_q;
  assign bus.ready_o         = ready_q;
  assign bus.calib_timeout_o = timeout_q;

endmodule

// File: tb/tb_fpga_boot_seq.sv
// tb/tb_fpga_boot_seq.sv - directed self-checking bench for fpga_boot_seq
module tb_fpga_boot_seq;

  logic clk = 1'b0;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  always #5 clk = ~clk;

  fpga_boot_seq_if bif ();

  fpga_boot_seq #(
    .LockDebounceCycles(8),
    .RstHoldCycles     (4),
    .CalibTimeoutCycles(32),
    .MaxRetries        (2),
    .SyncStages        (2),
    .CntWidth          (24)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.mmcm_locked_i    = 1'b0;
    bif.ddr_calib_done_i = 1'b0;
    bif.soft_rst_i       = 1'b0;
    bif.boot_mode_i      = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = -1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bif.mmcm_locked_i    = 1'b0;
    bif.ddr_calib_done_i = 1'b0;
    bif.soft_rst_i       = 1'b0;
    bif.boot_mode_i      = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bif.state_o, 0);
    chk("rst_soc", bif.soc_rst_no, 0);
    chk("rst_ddr", bif.ddr_rst_o, 1);
    chk("rst_boot", bif.boot_mode_o, 0);
    chk("rst_ready", bif.ready_o, 0);
    chk("rst_tmo", bif.calib_timeout_o, 0);

    // Nominal boot
    rst = 1'b0;
    cyc = -1;
    tick();
    bif.mmcm_locked_i = 1'b1;
    bif.boot_mode_i   = 2'd2;
    go(9);  chk("nom_wl9", bif.state_o, 0);
    go(10); chk("nom_ddr10", bif.state_o, 1);
            chk("nom_ddrrst10", bif.ddr_rst_o, 1);
    go(13); chk("nom_ddr13", bif.state_o, 1);
    go(14); chk("nom_wc14", bif.state_o, 2);
            chk("nom_ddrrel14", bif.ddr_rst_o, 0);
    go(20); bif.ddr_calib_done_i = 1'b1;
    go(22); chk("nom_wc22", bif.state_o, 2);
    go(23); chk("nom_soc23", bif.state_o, 3);
            chk("nom_boot23", bif.boot_mode_o, 2);
            chk("nom_socn23", bif.soc_rst_no, 0);
    go(26); chk("nom_soc26", bif.state_o, 3);
    go(27); chk("nom_run27", bif.state_o, 4);
            chk("nom_socn27", bif.soc_rst_no, 1);
            chk("nom_ready27", bif.ready_o, 1);
            chk("nom_ddr27", bif.ddr_rst_o, 0);

    // Soft reset in RUN
    go(30); bif.soft_rst_i = 1'b1; bif.boot_mode_i = 2'd1;
    go(31); chk("soft_soc31", bif.state_o, 3);
            chk("soft_socn31", bif.soc_rst_no, 0);
            chk("soft_ddr31", bif.ddr_rst_o, 0);
            chk("soft_boot31", bif.boot_mode_o, 1);
            chk("soft_ready31", bif.ready_o, 0);
    go(40); bif.soft_rst_i = 1'b0;
    go(43); chk("soft_soc43", bif.state_o, 3);
    go(44); chk("soft_run44", bif.state_o, 4);
            chk("soft_socn44", bif.soc_rst_no, 1);

    // Lock loss in RUN, relock, then asynchronous reset during DDR_RST
    go(50); bif.mmcm_locked_i = 1'b0;
    go(52); chk("loss_run52", bif.state_o, 4);
    go(53); chk("loss_wl53", bif.state_o, 0);
            chk("loss_socn53", bif.soc_rst_no, 0);
            chk("loss_ddr53", bif.ddr_rst_o, 1);
    bif.mmcm_locked_i = 1'b1;
    go(62); chk("relock_wl62", bif.state_o, 0);
    go(63); chk("relock_ddr63", bif.state_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", bif.state_o, 0);
    chk("arst_ddr", bif.ddr_rst_o, 1);
    chk("arst_soc", bif.soc_rst_no, 0);
    chk("arst_boot", bif.boot_mode_o, 0);
    chk("arst_ready", bif.ready_o, 0);

    // Lock glitch restarts debounce, then timeouts to ERROR
    do_reset();
    bif.mmcm_locked_i = 1'b1;
    go(6);  bif.mmcm_locked_i = 1'b0;
    go(7);  bif.mmcm_locked_i = 1'b1;
    go(16); chk("gl_wl16", bif.state_o, 0);
            chk("gl_ddr16", bif.ddr_rst_o, 1);
    go(17); chk("gl_ddr17", bif.state_o, 1);
    go(21); chk("to_wc21", bif.state_o, 2);
    go(52); chk("to_wc52", bif.state_o, 2);
            chk("to_tmo52", bif.calib_timeout_o, 0);
    go(53); chk("to_ddr53", bif.state_o, 1);
            chk("to_tmo53", bif.calib_timeout_o, 1);
    go(57); chk("to_wc57", bif.state_o, 2);
    go(89); chk("to_ddr89", bif.state_o, 1);
    go(93); chk("to_wc93", bif.state_o, 2);
    go(124); chk("to_wc124", bif.state_o, 2);
    go(125); chk("to_err125", bif.state_o, 5);
             chk("to_socn125", bif.soc_rst_no, 0);
             chk("to_ddr125", bif.ddr_rst_o, 1);
             chk("to_tmo125", bif.calib_timeout_o, 1);
    go(126); bif.mmcm_locked_i = 1'b0; bif.ddr_calib_done_i = 1'b1;
    go(140); chk("err_hold140", bif.state_o, 5);
             chk("err_socn140", bif.soc_rst_no, 0);
             chk("err_ddr140", bif.ddr_rst_o, 1);

    // Calibration arrives on the timeout cycle
    do_reset();
    bif.mmcm_locked_i = 1'b1;
    bif.boot_mode_i   = 2'd3;
    go(14); chk("tie_wc14", bif.state_o, 2);
    go(43); bif.ddr_calib_done_i = 1'b1;
    go(45); chk("tie_wc45", bif.state_o, 2);
    go(46); chk("tie_soc46", bif.state_o, 3);
            chk("tie_tmo46", bif.calib_timeout_o, 0);
            chk("tie_boot46", bif.boot_mode_o, 3);
    go(50); chk("tie_run50", bif.state_o, 4);
            chk("tie_tmo50", bif.calib_timeout_o, 0);
            chk("tie_socn50", bif.soc_rst_no, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_boot_seq.md
Name: fpga_boot_seq

Overview:
- Power-up and reset sequencer for the Xilinx FPGA top.
- Gates SoC and DRAM-controller resets on clock-wizard lock and DDR calibration, with debounce, calibration timeout, bounded retries and soft-reset support.
- Latches the boot mode at SoC reset release.
- Sits between the clock wizard / DRAM wrapper / VIO and the reset synchroniser feeding cheshire_soc.

Parameters:
- LockDebounceCycles, 1024: consecutive synced-lock cycles required before leaving WAIT_LOCK.
- RstHoldCycles, 64: cycles spent in DDR_RST and in SOC_RST.
- CalibTimeoutCycles, 2**22: cycles allowed in WAIT_CALIB before a timeout.
- MaxRetries, 3: DDR reset retries before ERROR.
- SyncStages, 2: synchroniser depth on mmcm_locked_i and ddr_calib_done_i.
- CntWidth, 24: shared counter width; must hold max(LockDebounceCycles, RstHoldCycles, CalibTimeoutCycles).

Ports:
- clk_i  in  1  SoC clock.
- rst_i  in  1  asynchronous active-high reset.
- mmcm_locked_i  in  1  clock-wizard locked, asynchronous.
- ddr_calib_done_i  in  1  DRAM calibration complete, asynchronous.
- soft_rst_i  in  1  level soft-reset request (VIO), synchronous to clk_i.
- boot_mode_i  in  2  boot mode from switches/VIO.
- soc_rst_no  out  1  SoC reset, active-low.
- ddr_rst_o  out  1  DRAM wrapper reset, active-high.
- boot_mode_o  out  2  boot mode latched at SOC_RST entry.
- state_o  out  3  current state encoding.
- ready_o  out  1  high in RUN.
- calib_timeout_o  out  1  sticky: at least one calibration timeout has occurred.

Behaviour:
- Clock and reset: one clock domain, clk_i. Reset rst_i is asynchronous and active-high; all flops clear on rst_i.
- Reset values: state=WAIT_LOCK, cnt=0, retry=0, soc_rst_no=0, ddr_rst_o=1, boot_mode_o=0, state_o=0, ready_o=0, calib_timeout_o=0.
- Synchronisers: lock_s and calib_s are SyncStages-flop copies of mmcm_locked_i and ddr_calib_done_i. All FSM decisions use only lock_s and calib_s.
- State encoding: WAIT_LOCK=0, DDR_RST=1, WAIT_CALIB=2, SOC_RST=3, RUN=4, ERROR=5.
- Outputs are registered: each is a function of the registered state, so outputs change in the same cycle the state register changes.
  - soc_rst_no=1 iff state==RUN.
  - ready_o=1 iff state==RUN.
  - ddr_rst_o=1 iff state is WAIT_LOCK, DDR_RST or ERROR.
- Counter: cnt is cleared on every state transition and otherwise increments by 1.
- WAIT_LOCK:
  - if !lock_s, cnt is held at 0;
  - if lock_s && cnt==LockDebounceCycles-1, go to DDR_RST.
- DDR_RST: if cnt==RstHoldCycles-1, go to WAIT_CALIB.
- WAIT_CALIB:
  - if calib_s, go to SOC_RST;
  - else if cnt==CalibTimeoutCycles-1:
    - set calib_timeout_o;
    - if retry==MaxRetries, go to ERROR;
    - else retry++ and go to DDR_RST.
  - If calib_s and the timeout coincide, calib_s wins.
- SOC_RST:
  - boot_mode_o <= boot_mode_i on the entry transition only;
  - while soft_rst_i is high, cnt is held at 0;
  - if !soft_rst_i && cnt==RstHoldCycles-1, go to RUN and clear retry.
- RUN, priority order:
  1. !lock_s: go to WAIT_LOCK;
  2. else !calib_s: go to DDR_RST;
  3. else soft_rst_i: go to SOC_RST (boot mode re-latched).
- In DDR_RST, WAIT_CALIB and SOC_RST, !lock_s has highest priority and forces WAIT_LOCK.
- ERROR is terminal: SoC stays in reset and DRAM stays in reset; it exits only via rst_i.
- calib_timeout_o is cleared only by rst_i.
- rst_i asserted mid-sequence returns the block to reset values immediately (asynchronous); sequencing restarts from WAIT_LOCK on deassertion.

Decomposition:
- Package fpga_boot_seq_pkg holds:
  - boot_state_e, 3-bit enum with the encodings above;
  - the default-parameter constants.
- Sub-module fpga_boot_seq_sync: a SyncStages-deep, async-active-high-reset 2-bit synchroniser for lock and calib. It is instantiated once, 2 bits wide.
- FSM and counter live in the top.

Test Plan:
All scenarios use LockDebounceCycles=8, RstHoldCycles=4, CalibTimeoutCycles=32, MaxRetries=2, SyncStages=2; cycle 0 is the first edge after rst_i deasserts.
- Nominal boot:
  - Stimulus: mmcm_locked_i=1 from cycle 0; ddr_calib_done_i=1 at cycle 20; boot_mode_i=2.
  - Response: state DDR_RST at cycle 10; WAIT_CALIB at 14; SOC_RST at 22 or 23; RUN 4 cycles later; soc_rst_no rises with ready_o; boot_mode_o=2.
- Lock glitch:
  - Stimulus: mmcm_locked_i drops for 1 cycle at cycle 6.
  - Response: debounce restarts, so DDR_RST entry is delayed to cycle 17; ddr_rst_o=1 throughout.
- Timeouts to ERROR:
  - Stimulus: calib never asserts.
  - Response: calib_timeout_o set after 32 cycles in WAIT_CALIB; 2 retries via DDR_RST; third timeout gives state_o=5; soc_rst_no stays 0 until rst_i.
- Timeout/calib tie:
  - Stimulus: calib_s rises exactly on cnt==31.
  - Response: SOC_RST entered; calib_timeout_o stays 0.
- Soft reset:
  - Stimulus: in RUN, soft_rst_i=1 for 10 cycles with boot_mode_i=1.
  - Response: state SOC_RST next cycle; soc_rst_no=0; ddr_rst_o stays 0; RUN again 4 cycles after soft_rst_i falls; boot_mode_o=1.
- Lock loss in RUN, then reset mid-sequence:
  - Stimulus: mmcm_locked_i=0 in RUN.
  - Response: WAIT_LOCK 3 cycles later; soc_rst_no=0 and ddr_rst_o=1 in the same cycle.
  - Follow-up: rst_i pulsed during DDR_RST returns all outputs to reset values asynchronously.
